mux_rr4: RTL and testbench
==========================

# mux_rr4

Round-robin 4-to-1 multiplexer with valid/ready handshake on every port. It arbitrates between four input channels and emits one beat per cycle on a single output stream. Each beat carries its data `d` and its source-channel select `s`. The output pair (`d`, `s`) is the exact form consumed by the team's 1-to-4 demultiplexer, so the block forms the transmit end of a shared-link channel pair.

## Interface
- `W`, default 1: data width per channel. `W`=1 matches the demux `d` input.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  4  per-channel request; bit i belongs to channel i.
- `in_data`  input  4*W  channel i data occupies bits [i*W +: W].
- `in_ready`  output  4  per-channel accept; at most one bit high; combinational.
- `d`  output  W  registered output data.
- `s`  output  2  registered source channel index of `d`.
- `out_valid`  output  1  registered; `d`/`s` hold a beat.
- `out_ready`  input  1  downstream accepts the beat.

## Operation
- Output register states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- Load enable: `load_en = rst_n & (~out_valid | out_ready)`.
- Arbitration:
  - Round-robin pointer `ptr[1:0]` names the highest-priority channel.
  - Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, mod 4.
  - Grant `g` is the first channel in that order with `in_valid[g]`=1.
- `in_ready[g]`=1 only when `load_en`=1 and a grant exists. All other bits are 0. A transfer on channel i occurs when `in_valid[i]` & `in_ready[i]`.
- On a transfer, at the next edge:
  - `d <= in_data[g*W +: W]`
  - `s <= g`
  - `out_valid <= 1`
  - `ptr <= g+1` mod 4 (3 wraps to 0)
- If `load_en`=1 with no request, `out_valid` <= 0 at the next edge. `d` and `s` hold their previous values.
- If `load_en`=0 (FULL and `out_ready`=0):
  - `d`, `s`, `out_valid` and `ptr` hold.
  - All `in_ready` bits are 0.
  - Output is stable until accepted.
- Transitions:
  - EMPTY to FULL on a grant.
  - FULL to FULL on (`out_ready` & grant), or on `~out_ready`.
  - FULL to EMPTY on `out_ready` with no request.
- `ptr` advances only on a grant. It never advances on idle or stalled cycles.
- Data is never reordered within a channel, dropped or duplicated. Each accepted input beat appears exactly once on the output.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `out_valid`=0, `d`=0, `s`=2'b00, `ptr`=0.
  - `in_ready`=4'b0000 combinationally for the whole time `rst_n` is low.
- Reset mid-operation discards any held beat. The first grant after reset starts the search at channel 0.
- Latency: input transfer at edge N gives `out_valid`=1 with that beat after edge N, i.e. one cycle.
- Throughput: one beat per cycle when `out_ready` is held high.
- Fairness: with all four channels requesting continuously and `out_ready`=1, grants follow the order 0,1,2,3,0,… Any channel waits at most 3 grants.
- Simultaneous drain and load in FULL with `out_ready`=1 and a request: the old beat leaves and the new beat loads at the same edge, with no bubble.
- `in_ready` depends combinationally on `in_valid`, `out_valid`, `out_ready`, `ptr` and `rst_n`. Upstream must not make `in_valid` depend on `in_ready`.

## Test plan
1. Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=4'b1111 → `out_valid`=0, `d`=0, `s`=0, `in_ready`=0. After release, the first output has `s`=0.
2. Single channel (`W`=8): `in_valid`=4'b0100, `in_data`[23:16]=8'hA5, `out_ready`=1 → `in_ready`=4'b0100. Next cycle `d`=8'hA5, `s`=2'b10, `out_valid`=1.
3. Round-robin: `in_valid`=4'b1111, `out_ready`=1, channel i data = 8'h10+i → output `s` sequence 0,1,2,3,0,1 and `d` sequence 10,11,12,13,10,11 (hex) on consecutive cycles.
4. Backpressure: output FULL with `d`=8'h11, `s`=1, then `out_ready`=0 for 5 cycles with requests pending → `d`/`s`/`out_valid` stable and `in_ready`=0 throughout. On `out_ready`=1, the next grant is channel 2.
5. Pointer wrap and skip: last grant channel 3, then `in_valid`=4'b0010 → grant is channel 1 and `ptr` becomes 2. Idle cycles with `in_valid`=0 leave `ptr` unchanged and drop `out_valid` to 0.
6. Reset mid-stream: assert `rst_n`=0 while FULL with `s`=3 → next cycle `out_valid`=0. After release with `in_valid`=4'b1010, the grant is channel 1.

Source files
------------

// File: rtl/mux_rr4_if.sv
// rtl/mux_rr4_if.sv - handshake bundle between four request channels and one output stream
//
// Purpose: groups the per-channel valid/data/ready signals and the muxed
// output stream (d, s, out_valid, out_ready) of mux_rr4.
// Ports (signals):
//   in_valid  [3:0]     per-channel request
//   in_data   [4*W-1:0] channel i data in bits [i*W +: W]
//   in_ready  [3:0]     per-channel accept, one-hot or zero
//   d         [W-1:0]   output beat data
//   s         [1:0]     output beat source channel
//   out_valid           output beat present
//   out_ready           downstream accepts the beat
// Modports: slave = the multiplexer, master = the upstream/downstream driver.
interface mux_rr4_if #(
  parameter int W = 1
);
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic [W-1:0]   d;
  logic [1:0]     s;
  logic           out_valid;
  logic           out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, d, s, out_valid
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, d, s, out_valid
  );
endinterface

// File: rtl/mux_rr4.sv
// rtl/mux_rr4.sv - round-robin 4-to-1 multiplexer with registered output beat
//
// Purpose: arbitrates four valid/ready channels round-robin and emits one
// beat per cycle as (d, s) with a registered out_valid.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mux_rr4_if.slave: in_valid/in_data/in_ready inputs side,
//          d/s/out_valid/out_ready output side
module mux_rr4 #(
  parameter int W = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  mux_rr4_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] d_q, d_d;
  logic [1:0]   s_q, s_d;
  logic [1:0]   ptr_q, ptr_d;

  logic         load_en;
  logic         grant_vld;
  logic [1:0]   grant;
  logic [1:0]   idx;

  // The register may take a new beat when empty or when its current beat
  // leaves this cycle; reset forces it closed so in_ready stays low.
  assign load_en = rst_n & ((state_q == EMPTY) | bus.out_ready);

  // First requesting channel starting at ptr; 2-bit addition wraps mod 4.
  always_comb begin
    grant_vld = 1'b0;
    grant     = ptr_q;
    idx       = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!grant_vld && bus.in_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  always_comb begin
    bus.in_ready = 4'b0000;
    if (load_en && grant_vld) begin
      bus.in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (grant_vld) begin
        state_d = FULL;
        d_d     = bus.in_data[grant*W +: W];
        s_d     = grant;
        ptr_d   = grant + 2'd1;
      end else begin
        // Drained with nothing to replace it; d/s keep their last values.
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      d_q     <= '0;
      s_q     <= 2'b00;
      ptr_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.d         = d_q;
  assign bus.s         = s_q;
  assign bus.out_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_rr4.sv
// tb/tb_mux_rr4.sv - self-checking bench for mux_rr4 (directed table plus random)
module tb_mux_rr4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_rr4_if #(.W(W)) bus ();

  mux_rr4 #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: behavioural state of the output register and priority pointer.
  int       m_valid = 0;
  int       m_d     = 0;
  int       m_s     = 0;
  int       m_ptr   = 0;
  logic [3:0] last_ready;

  typedef struct {
    logic        rn;
    logic [3:0]  iv;
    logic [31:0] dat;
    logic        ordy;
    logic [3:0]  er;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  es;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rn, input logic [3:0] iv, input logic [31:0] dat,
                              input logic ordy, input logic [3:0] er, input logic ev,
                              input logic [7:0] ed, input logic [1:0] es);
    vec_t v;
    v.rn = rn; v.iv = iv; v.dat = dat; v.ordy = ordy;
    v.er = er; v.ev = ev; v.ed = ed; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One cycle: drive, check in_ready against the model, clock, check outputs.
  task automatic step(input logic rn, input logic [3:0] iv, input logic [31:0] dat,
                      input logic ordy);
    int g;
    int load;
    int exp_ready;
    @(negedge clk);
    rst_n         = rn;
    bus.in_valid  = iv;
    bus.in_data   = dat;
    bus.out_ready = ordy;
    #1;
    load = (rn && (!m_valid || ordy)) ? 1 : 0;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && iv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    exp_ready = (load && g >= 0) ? (1 << g) : 0;
    last_ready = bus.in_ready;
    chk("in_ready", int'(bus.in_ready), exp_ready);
    @(posedge clk);
    #1;
    if (!rn) begin
      m_valid = 0; m_d = 0; m_s = 0; m_ptr = 0;
    end else if (load) begin
      if (g >= 0) begin
        m_valid = 1;
        m_d     = (dat >> (8 * g)) & 8'hFF;
        m_s     = g;
        m_ptr   = (g + 1) % 4;
      end else begin
        m_valid = 0;
      end
    end
    chk("out_valid", int'(bus.out_valid), m_valid);
    chk("d", int'(bus.d), m_d);
    chk("s", int'(bus.s), m_s);
  endtask

  localparam logic [31:0] RR = 32'h1312_1110;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'b0000;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // rn, iv, data, ordy | in_ready, out_valid, d, s (after the edge)
    tbl.push_back(mk(0, 4'b1111, RR, 1, 4'b0000, 0, 8'h00, 2'd0)); // reset
    tbl.push_back(mk(0, 4'b1111, RR, 1, 4'b0000, 0, 8'h00, 2'd0));
    tbl.push_back(mk(1, 4'b0100, 32'h00A5_0000, 1, 4'b0100, 1, 8'hA5, 2'd2)); // single channel
    tbl.push_back(mk(1, 4'b1111, RR, 1, 4'b1000, 1, 8'h13, 2'd3));
    tbl.push_back(mk(1, 4'b1111, RR, 1, 4'b0001, 1, 8'h10, 2'd0));
    tbl.push_back(mk(1, 4'b1111, RR, 1, 4'b0010, 1, 8'h11, 2'd1));
    tbl.push_back(mk(1, 4'b1111, RR, 0, 4'b0000, 1, 8'h11, 2'd1)); // backpressure x5
    tbl.push_back(mk(1, 4'b1111, RR, 0, 4'b0000, 1, 8'h11, 2'd1));
    tbl.push_back(mk(1, 4'b1111, RR, 0, 4'b0000, 1, 8'h11, 2'd1));
    tbl.push_back(mk(1, 4'b1111, RR, 0, 4'b0000, 1, 8'h11, 2'd1));
    tbl.push_back(mk(1, 4'b1111, RR, 0, 4'b0000, 1, 8'h11, 2'd1));
    tbl.push_back(mk(1, 4'b1111, RR, 1, 4'b0100, 1, 8'h12, 2'd2)); // resumes at channel 2
    tbl.push_back(mk(1, 4'b1111, RR, 1, 4'b1000, 1, 8'h13, 2'd3));
    tbl.push_back(mk(1, 4'b0010, RR, 1, 4'b0010, 1, 8'h11, 2'd1)); // wrap and skip
    tbl.push_back(mk(1, 4'b0000, RR, 1, 4'b0000, 0, 8'h11, 2'd1)); // idle
    tbl.push_back(mk(1, 4'b0000, RR, 1, 4'b0000, 0, 8'h11, 2'd1));
    tbl.push_back(mk(1, 4'b1111, RR, 1, 4'b0100, 1, 8'h12, 2'd2)); // ptr held at 2
    tbl.push_back(mk(1, 4'b1000, RR, 1, 4'b1000, 1, 8'h13, 2'd3));
    tbl.push_back(mk(0, 4'b1111, RR, 1, 4'b0000, 0, 8'h00, 2'd0)); // reset while FULL, s=3
    tbl.push_back(mk(1, 4'b1010, RR, 1, 4'b0010, 1, 8'h11, 2'd1));
    tbl.push_back(mk(0, 4'b1111, RR, 1, 4'b0000, 0, 8'h00, 2'd0));
    tbl.push_back(mk(1, 4'b1111, RR, 1, 4'b0001, 1, 8'h10, 2'd0)); // fairness 0,1,2,3,0,1
    tbl.push_back(mk(1, 4'b1111, RR, 1, 4'b0010, 1, 8'h11, 2'd1));
    tbl.push_back(mk(1, 4'b1111, RR, 1, 4'b0100, 1, 8'h12, 2'd2));
    tbl.push_back(mk(1, 4'b1111, RR, 1, 4'b1000, 1, 8'h13, 2'd3));
    tbl.push_back(mk(1, 4'b1111, RR, 1, 4'b0001, 1, 8'h10, 2'd0));
    tbl.push_back(mk(1, 4'b1111, RR, 1, 4'b0010, 1, 8'h11, 2'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rn, tbl[i].iv, tbl[i].dat, tbl[i].ordy);
      chk($sformatf("vec%0d in_ready", i), int'(last_ready), int'(tbl[i].er));
      chk($sformatf("vec%0d out_valid", i), int'(bus.out_valid), int'(tbl[i].ev));
      chk($sformatf("vec%0d d", i), int'(bus.d), int'(tbl[i].ed));
      chk($sformatf("vec%0d s", i), int'(bus.s), int'(tbl[i].es));
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) != 0), 4'($urandom), $urandom, 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
